// File: rtl/tile_scheduler.sv
// tile_scheduler: walks the (m, n, k) tile space of one GEMM job and issues
// one tile command at a time to the systolic core over valid/ready.
// Optional feature macro: TILE_SCHED_PERF_EN builds the performance counters
// (perf_tiles, perf_stall_cycles); without it both read as 0.
module tile_scheduler #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_pulse,
  input  logic             abort_pulse,
  input  logic [DIM_W-1:0] M,
  input  logic [DIM_W-1:0] N,
  input  logic [DIM_W-1:0] K,
  input  logic [DIM_W-1:0] Tm,
  input  logic [DIM_W-1:0] Tn,
  input  logic [DIM_W-1:0] Tk,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [DIM_W-1:0] tile_m_off,
  output logic [DIM_W-1:0] tile_n_off,
  output logic [DIM_W-1:0] tile_k_off,
  output logic [DIM_W-1:0] tile_m_sz,
  output logic [DIM_W-1:0] tile_n_sz,
  output logic [DIM_W-1:0] tile_k_sz,
  output logic             tile_first_k,
  output logic             tile_last_k,
  input  logic             tile_done,
  output logic             core_abort,
  output logic             core_busy,
  output logic             core_done_tile_pulse,
  output logic             job_done_pulse,
  output logic             core_bank_sel_rd_A,
  output logic             core_bank_sel_rd_B,
  output logic [31:0]      perf_tiles,
  output logic [31:0]      perf_stall_cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ADV   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [DIM_W-1:0] r_m, r_n, r_k, r_tm, r_tn, r_tk;
  logic [DIM_W-1:0] r_m_off, r_n_off, r_k_off;
  logic [DIM_W-1:0] r_m_sz, r_n_sz, r_k_sz;
  logic             r_first_k, r_last_k, r_bank, r_core_abort;

  logic [DIM_W:0]   w_m_nx, w_n_nx, w_k_nx;
  logic             w_m_wrap, w_n_wrap, w_k_wrap, w_last_job;
  logic [DIM_W-1:0] w_m_new, w_n_new, w_k_new;
  logic             w_abort, w_start, w_zero_dim;

  // Extent of a tile starting at off, clipped at the job edge.
  function automatic logic [DIM_W-1:0] f_clip(input logic [DIM_W-1:0] t,
                                              input logic [DIM_W-1:0] dim,
                                              input logic [DIM_W-1:0] off);
    logic [DIM_W-1:0] rem;
    rem = dim - off;
    return (t < rem) ? t : rem;
  endfunction

  assign w_abort    = abort_pulse && (r_state != S_IDLE);
  assign w_start    = start_pulse && !abort_pulse && (r_state == S_IDLE);
  assign w_zero_dim = (M == '0) || (N == '0) || (K == '0);

  // Next offsets of the k-inner / n / m-outer loop nest, one bit wider so the
  // wrap compare cannot overflow.
  always_comb begin
    w_k_nx     = {1'b0, r_k_off} + {1'b0, r_tk};
    w_n_nx     = {1'b0, r_n_off} + {1'b0, r_tn};
    w_m_nx     = {1'b0, r_m_off} + {1'b0, r_tm};
    w_k_wrap   = w_k_nx >= {1'b0, r_k};
    w_n_wrap   = w_n_nx >= {1'b0, r_n};
    w_m_wrap   = w_m_nx >= {1'b0, r_m};
    w_k_new    = w_k_wrap ? '0 : w_k_nx[DIM_W-1:0];
    w_n_new    = !w_k_wrap ? r_n_off : (w_n_wrap ? '0 : w_n_nx[DIM_W-1:0]);
    w_m_new    = (w_k_wrap && w_n_wrap) ? w_m_nx[DIM_W-1:0] : r_m_off;
    w_last_job = w_k_wrap && w_n_wrap && w_m_wrap;
  end

  // Control FSM, job latch, tile field registers and bank toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_m          <= '0;
      r_n          <= '0;
      r_k          <= '0;
      r_tm         <= '0;
      r_tn         <= '0;
      r_tk         <= '0;
      r_m_off      <= '0;
      r_n_off      <= '0;
      r_k_off      <= '0;
      r_m_sz       <= '0;
      r_n_sz       <= '0;
      r_k_sz       <= '0;
      r_first_k    <= 1'b0;
      r_last_k     <= 1'b0;
      r_bank       <= 1'b0;
      r_core_abort <= 1'b0;
    end else begin
      r_core_abort <= w_abort;
      if (w_abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (w_start) begin
            r_m       <= M;
            r_n       <= N;
            r_k       <= K;
            r_tm      <= Tm;
            r_tn      <= Tn;
            r_tk      <= Tk;
            r_m_off   <= '0;
            r_n_off   <= '0;
            r_k_off   <= '0;
            r_m_sz    <= f_clip(Tm, M, '0);
            r_n_sz    <= f_clip(Tn, N, '0);
            r_k_sz    <= f_clip(Tk, K, '0);
            r_first_k <= 1'b1;
            r_last_k  <= Tk >= K;
            r_bank    <= 1'b0;
            r_state   <= w_zero_dim ? S_DONE : S_ISSUE;
          end
          S_ISSUE: if (tile_ready) r_state <= S_WAIT;
          S_WAIT: if (tile_done) begin
            r_bank  <= ~r_bank;
            r_state <= S_ADV;
          end
          S_ADV: if (w_last_job) begin
            r_state <= S_DONE;
          end else begin
            r_m_off   <= w_m_new;
            r_n_off   <= w_n_new;
            r_k_off   <= w_k_new;
            r_m_sz    <= f_clip(r_tm, r_m, w_m_new);
            r_n_sz    <= f_clip(r_tn, r_n, w_n_new);
            r_k_sz    <= f_clip(r_tk, r_k, w_k_new);
            r_first_k <= w_k_new == '0;
            r_last_k  <= ({1'b0, w_k_new} + {1'b0, r_tk}) >= {1'b0, r_k};
            r_state   <= S_ISSUE;
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tile_valid           = r_state == S_ISSUE;
  assign core_busy            = r_state != S_IDLE;
  assign job_done_pulse       = r_state == S_DONE;
  assign core_abort           = r_core_abort;
  assign tile_m_off           = r_m_off;
  assign tile_n_off           = r_n_off;
  assign tile_k_off           = r_k_off;
  assign tile_m_sz            = r_m_sz;
  assign tile_n_sz            = r_n_sz;
  assign tile_k_sz            = r_k_sz;
  assign tile_first_k         = r_first_k;
  assign tile_last_k          = r_last_k;
  assign core_bank_sel_rd_A   = r_bank;
  assign core_bank_sel_rd_B   = r_bank;
  // Output tile finished: combinational so it lines up with tile_done.
  assign core_done_tile_pulse = (r_state == S_WAIT) && tile_done && r_last_k && !abort_pulse;

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] r_perf_tiles, r_perf_stall;
  logic        w_accept, w_stall;

  assign w_accept = tile_valid && tile_ready && !abort_pulse;
  assign w_stall  = tile_valid && !tile_ready;

  // Saturating counters of accepted tiles and backpressure cycles.
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_perf_tiles <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept && (r_perf_tiles != '1)) r_perf_tiles <= r_perf_tiles + 32'd1;
      if (w_stall  && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_tiles        = r_perf_tiles;
  assign perf_stall_cycles = r_perf_stall;
`else
  assign perf_tiles        = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: randomized job runs checked against a loop-nest model of
// the tile sequence, plus directed reset, backpressure and abort cases.
module tb_tile_scheduler;
  localparam int DIM_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_pulse = 1'b0, abort_pulse = 1'b0;
  logic [DIM_W-1:0] M = '0, N = '0, K = '0, Tm = '0, Tn = '0, Tk = '0;
  logic             tile_valid, tile_ready = 1'b0, tile_done = 1'b0;
  logic [DIM_W-1:0] tile_m_off, tile_n_off, tile_k_off;
  logic [DIM_W-1:0] tile_m_sz, tile_n_sz, tile_k_sz;
  logic             tile_first_k, tile_last_k;
  logic             core_abort, core_busy, core_done_tile_pulse, job_done_pulse;
  logic             core_bank_sel_rd_A, core_bank_sel_rd_B;
  logic [31:0]      perf_tiles, perf_stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int m, n, k, ms, ns, ks;
    bit f, l;
  } tile_t;

  tile_scheduler #(.DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .abort_pulse(abort_pulse),
    .M(M), .N(N), .K(K), .Tm(Tm), .Tn(Tn), .Tk(Tk),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_m_off(tile_m_off), .tile_n_off(tile_n_off), .tile_k_off(tile_k_off),
    .tile_m_sz(tile_m_sz), .tile_n_sz(tile_n_sz), .tile_k_sz(tile_k_sz),
    .tile_first_k(tile_first_k), .tile_last_k(tile_last_k),
    .tile_done(tile_done), .core_abort(core_abort), .core_busy(core_busy),
    .core_done_tile_pulse(core_done_tile_pulse), .job_done_pulse(job_done_pulse),
    .core_bank_sel_rd_A(core_bank_sel_rd_A), .core_bank_sel_rd_B(core_bank_sel_rd_B),
    .perf_tiles(perf_tiles), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected tile sequence straight from the loop nest definition.
  task automatic build(input int m_, n_, k_, tm, tn, tk, output tile_t q[$], output int n_out);
    tile_t t;
    q = {};
    n_out = 0;
    for (int mm = 0; mm < m_; mm += tm)
      for (int nn = 0; nn < n_; nn += tn) begin
        n_out++;
        for (int kk = 0; kk < k_; kk += tk) begin
          t.m = mm; t.n = nn; t.k = kk;
          t.ms = min2(tm, m_ - mm); t.ns = min2(tn, n_ - nn); t.ks = min2(tk, k_ - kk);
          t.f = (kk == 0); t.l = (kk + tk >= k_);
          q.push_back(t);
        end
      end
  endtask

  task automatic chk_tile(input tile_t c);
    chk("m_off", tile_m_off, c.m);  chk("n_off", tile_n_off, c.n);  chk("k_off", tile_k_off, c.k);
    chk("m_sz", tile_m_sz, c.ms);   chk("n_sz", tile_n_sz, c.ns);   chk("k_sz", tile_k_sz, c.ks);
    chk("first_k", tile_first_k, c.f); chk("last_k", tile_last_k, c.l);
  endtask

  task automatic run_job(input int m_, n_, k_, tm, tn, tk, input int stall_pct, input bit extra_start);
    tile_t q[$];
    tile_t cur;
    int n_out, total, cyc, tiles, dtp, stalls, wait_cnt, last_done;
    bit pend, fresh, done_seen, injected, exp_bank;
    build(m_, n_, k_, tm, tn, tk, q, n_out);
    total = q.size();
    cyc = 0; tiles = 0; dtp = 0; stalls = 0; wait_cnt = 0; last_done = -100;
    pend = 0; fresh = 0; done_seen = 0; injected = 0; exp_bank = 0;
    @(negedge clk);
    M = m_[DIM_W-1:0]; N = n_[DIM_W-1:0]; K = k_[DIM_W-1:0];
    Tm = tm[DIM_W-1:0]; Tn = tn[DIM_W-1:0]; Tk = tk[DIM_W-1:0];
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    chk("busy_T1", core_busy, 1);
    if (total == 0) begin
      chk("zero_jd_T1", job_done_pulse, 1);
      chk("zero_valid", tile_valid, 0);
      @(negedge clk);
      chk("zero_busy_T2", core_busy, 0);
      chk("zero_valid_T2", tile_valid, 0);
      return;
    end
    chk("valid_T1", tile_valid, 1);
    while (!done_seen && cyc < 20000) begin
      tile_ready = 1'b0; tile_done = 1'b0; start_pulse = 1'b0;
      M = m_[DIM_W-1:0];
      if (job_done_pulse) begin
        done_seen = 1;
        chk("jd_latency", cyc - last_done, 2);
        chk("jd_busy", core_busy, 1);
        break;
      end
      if (tile_valid) begin
        if (q.size() == 0) begin
          chk("extra_tile", 1, 0);
          break;
        end
        cur = q[0];
        chk_tile(cur);
        if (fresh) begin
          chk("tile_gap", cyc - last_done, 2);
          chk("bank_A", core_bank_sel_rd_A, exp_bank);
          fresh = 0;
        end
        if ($urandom_range(99) >= stall_pct) begin
          tile_ready = 1'b1;
          void'(q.pop_front());
          tiles++;
          pend = 1;
          wait_cnt = $urandom_range(3);
        end else stalls++;
      end else if (pend) begin
        if (extra_start && !injected) begin
          start_pulse = 1'b1;
          M = m_[DIM_W-1:0] + 16'd3;
          injected = 1;
        end
        if (wait_cnt == 0) begin
          tile_done = 1'b1;
          #1;
          chk("done_tile_pulse", core_done_tile_pulse, cur.l);
          if (cur.l) dtp++;
          pend = 0; fresh = 1; last_done = cyc; exp_bank = ~exp_bank;
        end else wait_cnt--;
      end
      @(negedge clk);
      cyc++;
    end
    tile_ready = 1'b0; tile_done = 1'b0; start_pulse = 1'b0;
    chk("job_done_seen", done_seen, 1);
    chk("tiles_issued", tiles, total);
    chk("out_tiles", dtp, n_out);
    chk("bank_B_end", core_bank_sel_rd_B, exp_bank);
`ifdef TILE_SCHED_PERF_EN
    chk("perf_tiles", perf_tiles, tiles);
    chk("perf_stall", perf_stall_cycles, stalls);
`else
    chk("perf_tiles", perf_tiles, 0);
    chk("perf_stall", perf_stall_cycles, 0);
`endif
    @(negedge clk);
    chk("idle_busy", core_busy, 0);
    chk("idle_jd", job_done_pulse, 0);
  endtask

  initial begin
    int m_, n_, k_;
    tile_t c;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", tile_valid, 0);     chk("rst_busy", core_busy, 0);
    chk("rst_jd", job_done_pulse, 0);    chk("rst_abort", core_abort, 0);
    chk("rst_m_off", tile_m_off, 0);     chk("rst_k_sz", tile_k_sz, 0);
    chk("rst_bank", core_bank_sel_rd_A, 0);
    chk("rst_perf", perf_tiles, 0);

    run_job(4, 4, 4, 2, 2, 2, 0, 0);     // basic loop nest
    run_job(5, 1, 1, 2, 1, 1, 0, 0);     // edge clipping
    run_job(4, 4, 0, 2, 2, 2, 0, 0);     // zero dimension
    run_job(3, 5, 7, 2, 2, 3, 20, 1);    // start while busy ignored

    // Backpressure: first tile held for 3 cycles, then abort in WAIT with tile_done.
    @(negedge clk);
    M = 16'd4; N = 16'd4; K = 16'd4; Tm = 16'd2; Tn = 16'd2; Tk = 16'd2;
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    c.m = 0; c.n = 0; c.k = 0; c.ms = 2; c.ns = 2; c.ks = 2; c.f = 1; c.l = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", tile_valid, 1);
      chk_tile(c);
      @(negedge clk);
    end
    chk("bp_valid_end", tile_valid, 1);
    tile_ready = 1'b1;
    @(negedge clk);
    tile_ready = 1'b0;
    chk("bp_wait_valid", tile_valid, 0);
`ifdef TILE_SCHED_PERF_EN
    chk("bp_perf_stall", perf_stall_cycles, 3);
    chk("bp_perf_tiles", perf_tiles, 1);
`else
    chk("bp_perf_stall", perf_stall_cycles, 0);
    chk("bp_perf_tiles", perf_tiles, 0);
`endif
    tile_done = 1'b1; abort_pulse = 1'b1;
    #1;
    chk("abort_no_dtp", core_done_tile_pulse, 0);
    @(negedge clk);
    tile_done = 1'b0; abort_pulse = 1'b0;
    chk("abort_core_abort", core_abort, 1);
    chk("abort_busy", core_busy, 0);
    chk("abort_jd", job_done_pulse, 0);
    chk("abort_bank", core_bank_sel_rd_A, 0);
    @(negedge clk);
    chk("abort_one_cycle", core_abort, 0);
    chk("abort_stays_idle", tile_valid, 0);

    // Abort together with start in IDLE: start ignored, no abort forwarded.
    start_pulse = 1'b1; abort_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0; abort_pulse = 1'b0;
    chk("abort_start_busy", core_busy, 0);
    chk("abort_idle_fwd", core_abort, 0);

    // Randomized jobs.
    for (int j = 0; j < 8; j++) begin
      m_ = $urandom_range(1, 9); n_ = $urandom_range(1, 9); k_ = $urandom_range(1, 9);
      if ($urandom_range(7) == 0) k_ = 0;
      run_job(m_, n_, k_, $urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5),
              30, j[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
